// File: rtl/waterfall_led_ctrl.sv
// waterfall_led_ctrl: chaser LED controller with prescaled step tick, speed select, four motion modes
// and registered outputs. Define WATERFALL_TRAIL_EN to add a one-LED trail in the single-dot modes.
module waterfall_led_ctrl #(
  parameter int NUM_LEDS = 8,
  parameter int TICK_DIV = 50_000_000,
  localparam int POS_W = $clog2(NUM_LEDS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr_n,
  input  logic                stop_n,
  input  logic [1:0]          mode,
  input  logic [1:0]          speed,
  output logic [NUM_LEDS-1:0] led,
  output logic [POS_W-1:0]    pos,
  output logic                step
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LEDS - 1);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  logic [PRE_W-1:0]    pre_reg;
  logic [2:0]          post_reg;
  logic [POS_W-1:0]    pos_reg;
  dir_t                dir_reg;
  logic                step_reg;
  logic [NUM_LEDS-1:0] led_reg;

  logic                base_tick;
  logic                step_fire;
  logic [2:0]          post_mask;
  logic [POS_W-1:0]    move_pos;
  dir_t                move_dir;
  logic [POS_W-1:0]    pos_next;
  dir_t                dir_next;
  logic [POS_W-1:0]    trail_next;
  logic [NUM_LEDS-1:0] bar_bits;
  logic [NUM_LEDS-1:0] dot_bits;
  logic [NUM_LEDS-1:0] led_next;

`ifdef WATERFALL_TRAIL_EN
  logic [POS_W-1:0]    trail_reg;
`endif

  always_comb begin
    case (speed)
      2'b00:   post_mask = 3'b000;
      2'b01:   post_mask = 3'b001;
      2'b10:   post_mask = 3'b011;
      default: post_mask = 3'b111;
    endcase
    base_tick = (pre_reg == PRE_LAST);
    step_fire = base_tick && ((post_reg & post_mask) == post_mask);

    move_pos = pos_reg;
    move_dir = dir_reg;
    case (mode)
      2'b01: move_pos = (pos_reg == '0) ? POS_LAST : pos_reg - POS_W'(1);
      2'b10: begin
        // Ping-pong turns around on the end step itself, so end LEDs never dwell.
        if (dir_reg == DIR_UP) begin
          if (pos_reg == POS_LAST) begin
            move_pos = POS_LAST - POS_W'(1);
            move_dir = DIR_DOWN;
          end else begin
            move_pos = pos_reg + POS_W'(1);
          end
        end else begin
          if (pos_reg == '0) begin
            move_pos = POS_W'(1);
            move_dir = DIR_UP;
          end else begin
            move_pos = pos_reg - POS_W'(1);
          end
        end
      end
      default: move_pos = (pos_reg == POS_LAST) ? '0 : pos_reg + POS_W'(1);
    endcase

    if (!clr_n) begin
      pos_next = '0;
      dir_next = DIR_UP;
    end else if (stop_n && step_fire) begin
      pos_next = move_pos;
      dir_next = move_dir;
    end else begin
      pos_next = pos_reg;
      dir_next = dir_reg;
    end

`ifdef WATERFALL_TRAIL_EN
    if (!clr_n)
      trail_next = '0;
    else if (stop_n && step_fire)
      trail_next = pos_reg;
    else
      trail_next = trail_reg;
`else
    trail_next = pos_next;
`endif
  end

  // LED pattern is built from the next position so led and pos change on the same edge.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LEDS; gi++) begin : g_pattern
      assign bar_bits[gi] = (POS_W'(gi) <= pos_next);
      assign dot_bits[gi] = (pos_next == POS_W'(gi)) || (trail_next == POS_W'(gi));
    end
  endgenerate

  assign led_next = (mode == 2'b11) ? bar_bits : dot_bits;

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_reg  <= '0;
      post_reg <= '0;
      pos_reg  <= '0;
      dir_reg  <= DIR_UP;
      step_reg <= 1'b0;
      led_reg  <= '0;
`ifdef WATERFALL_TRAIL_EN
      trail_reg <= '0;
`endif
    end else begin
      pos_reg <= pos_next;
      dir_reg <= dir_next;
      led_reg <= en ? led_next : '0;
`ifdef WATERFALL_TRAIL_EN
      trail_reg <= trail_next;
`endif
      if (!clr_n) begin
        pre_reg  <= '0;
        post_reg <= '0;
        step_reg <= 1'b0;
      end else if (!stop_n) begin
        step_reg <= 1'b0;
      end else begin
        pre_reg  <= base_tick ? '0 : pre_reg + PRE_W'(1);
        step_reg <= step_fire;
        if (base_tick)
          post_reg <= step_fire ? 3'b000 : post_reg + 3'b001;
      end
    end
  end

  assign led  = led_reg;
  assign pos  = pos_reg;
  assign step = step_reg;

endmodule

// File: tb/tb_waterfall_led_ctrl.sv
// tb_waterfall_led_ctrl: randomized stimulus on an 8-LED and a 5-LED instance, each compared
// every cycle against a behavioural model of the chaser.
module tb_waterfall_led_ctrl;

  logic       clk = 1'b0;
  logic       rst, en, clr_n, stop_n;
  logic [1:0] mode, speed;
  logic [7:0] led8;
  logic [2:0] pos8;
  logic       step8;
  logic [4:0] led5;
  logic [2:0] pos5;
  logic       step5;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  waterfall_led_ctrl #(.NUM_LEDS(8), .TICK_DIV(4)) u_dut8 (
    .clk(clk), .rst(rst), .en(en), .clr_n(clr_n), .stop_n(stop_n),
    .mode(mode), .speed(speed), .led(led8), .pos(pos8), .step(step8));

  waterfall_led_ctrl #(.NUM_LEDS(5), .TICK_DIV(3)) u_dut5 (
    .clk(clk), .rst(rst), .en(en), .clr_n(clr_n), .stop_n(stop_n),
    .mode(mode), .speed(speed), .led(led5), .pos(pos5), .step(step5));

  // Model state per instance: index 0 = 8 LEDs / TICK_DIV 4, index 1 = 5 LEDs / TICK_DIV 3.
  int n_leds [2] = '{8, 5};
  int t_div  [2] = '{4, 3};
  int m_pre  [2];
  int m_ticks[2];
  int m_pos  [2];
  int m_up   [2];
  int m_trail[2];
  int m_step [2];
  int m_led  [2];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int pattern(input int m, input int p, input int t);
    if (m == 3) return (1 << (p + 1)) - 1;
`ifdef WATERFALL_TRAIL_EN
    return (1 << p) | (1 << t);
`else
    return (t >= 0) ? (1 << p) : 0;
`endif
  endfunction

  task automatic model_edge(input int k);
    int n;
    bit moved;
    n = n_leds[k];
    moved = 0;
    if (rst) begin
      m_pre[k] = 0; m_ticks[k] = 0; m_pos[k] = 0; m_up[k] = 1;
      m_trail[k] = 0; m_step[k] = 0; m_led[k] = 0;
      return;
    end
    if (!clr_n) begin
      m_pre[k] = 0; m_ticks[k] = 0; m_pos[k] = 0; m_up[k] = 1;
      m_trail[k] = 0; m_step[k] = 0;
    end else if (!stop_n) begin
      m_step[k] = 0;
    end else begin
      m_step[k] = 0;
      if (m_pre[k] == t_div[k] - 1) begin
        m_pre[k] = 0;
        m_ticks[k]++;
        // A step happens once every 2**speed base ticks since the previous step.
        if (m_ticks[k] % (1 << speed) == 0) begin
          m_ticks[k] = 0;
          m_step[k] = 1;
          moved = 1;
        end
      end else begin
        m_pre[k]++;
      end
    end
    if (moved) begin
      m_trail[k] = m_pos[k];
      case (mode)
        2'd1: m_pos[k] = (m_pos[k] + n - 1) % n;
        2'd2: begin
          if (m_up[k] != 0 && m_pos[k] == n - 1) m_up[k] = 0;
          else if (m_up[k] == 0 && m_pos[k] == 0) m_up[k] = 1;
          m_pos[k] = m_up[k] != 0 ? m_pos[k] + 1 : m_pos[k] - 1;
        end
        default: m_pos[k] = (m_pos[k] + 1) % n;
      endcase
    end
    m_led[k] = en ? pattern(int'(mode), m_pos[k], m_trail[k]) : 0;
  endtask

  int stop_left = 0;
  int blank_left = 0;

  initial begin
    rst = 1'b1; en = 1'b1; clr_n = 1'b1; stop_n = 1'b1; mode = 2'd0; speed = 2'd0;
    for (cyc = 0; cyc < 6000; cyc++) begin
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      @(negedge clk);
      check("pos8",  int'(pos8),  m_pos[0]);
      check("step8", int'(step8), m_step[0]);
      check("led8",  int'(led8),  m_led[0]);
      check("pos5",  int'(pos5),  m_pos[1]);
      check("step5", int'(step5), m_step[1]);
      check("led5",  int'(led5),  m_led[1]);

      if (cyc < 3) begin
        rst = 1'b1;
      end else if (cyc < 120) begin
        // Directed warm-up: plain shift-up, then ping-pong, at full speed.
        rst = 1'b0;
        mode = (cyc < 60) ? 2'd0 : 2'd2;
      end else begin
        rst   = ($urandom_range(0, 299) == 0);
        clr_n = ($urandom_range(0, 79) != 0);
        if (stop_left > 0) stop_left--;
        else if ($urandom_range(0, 99) == 0) stop_left = 20;
        stop_n = (stop_left == 0);
        if (blank_left > 0) blank_left--;
        else if ($urandom_range(0, 119) == 0) blank_left = 15;
        en = (blank_left == 0);
        if ($urandom_range(0, 69) == 0) mode = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 89) == 0) speed = 2'($urandom_range(0, 3));
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
